// File: rtl/serial_add_pkg.sv
// ============================================================================
//  Module   : serial_add_pkg
//  Purpose  : Shared state encoding, default width and counter sizing for
//             the bit-serial adder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/half_adder.sv
// ============================================================================
//  Module   : half_adder
//  Purpose  : Single-bit half adder, s = a ^ b, c = a & b.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
//  Module   : serial_add_ctrl
//  Purpose  : Bit-serial adder, one full-adder cell processing one bit per
//             cycle LSB first, with IDLE/SHIFT/DONE control and held outputs.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int             c_cnt_w    = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_shift;
  logic                 w_last;

  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  // Holds the WIDTH-1 upper sum bits gathered so far; the current sum bit
  // completes the word on the final shift.
  logic [WIDTH-2:0]     r_res;
  logic                 r_carry;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_sum_out;
  logic                 r_cout;

  logic                 w_s0;
  logic                 w_c0;
  logic                 w_c1;
  logic                 w_sum;
  logic                 w_cout;
  logic [WIDTH-1:0]     w_res_shift;

  // Full adder built from two half adders and an OR.
  half_adder u_ha0 (
    .a (r_a[0]),
    .b (r_b[0]),
    .s (w_s0),
    .c (w_c0)
  );

  half_adder u_ha1 (
    .a (w_s0),
    .b (r_carry),
    .s (w_sum),
    .c (w_c1)
  );

  assign w_cout      = w_c0 | w_c1;
  assign w_res_shift = {w_sum, r_res};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == c_last_cnt) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sum_out <= '0;
      r_cout    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_a     <= a_in;
        r_b     <= b_in;
        r_carry <= 1'b0;
        r_cnt   <= '0;
      end else if (w_shift) begin
        r_a     <= {1'b0, r_a[WIDTH-1:1]};
        r_b     <= {1'b0, r_b[WIDTH-1:1]};
        r_res   <= w_res_shift[WIDTH-1:1];
        r_carry <= w_cout;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_sum_out <= w_res_shift;
        r_cout    <= w_cout;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign sum_out = r_sum_out;
  assign cout    = r_cout;

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request to add the operands; level-sampled on each clk edge.
REQ-005 Port: a_in  input  WIDTH  operand A; sampled only on the accepting edge.
REQ-006 Port: b_in  input  WIDTH  operand B; sampled only on the accepting edge.
REQ-007 Port: busy  output  1  high while an addition is in progress (SHIFT or DONE state).
REQ-008 Port: done  output  1  one-cycle pulse marking that the result is valid.
REQ-009 Port: sum_out  output  WIDTH  result of A+B modulo 2^WIDTH; held between operations.
REQ-010 Port: cout  output  1  carry out of the MSB; held with sum_out.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at an edge, the block SHALL do all of the following: capture a_in/b_in into shift registers, clear the carry register, clear the bit counter and move to SHIFT.
REQ-013 The block SHALL use a single 1-bit full-adder cell, built from two half-adders and an OR, to process one bit pair (LSB first) per SHIFT cycle.
REQ-014 On each SHIFT edge, the block SHALL do all of the following: shift the sum bit into the MSB of the result register, shift both operand registers right by one, latch the new carry and increment the counter.
REQ-015 After exactly WIDTH SHIFT cycles, the FSM SHALL enter DONE.
REQ-016 On entry to DONE, sum_out and cout SHALL update to the final result and carry.
REQ-017 The FSM SHALL stay in DONE for exactly one cycle, with done=1, and then return to IDLE.
REQ-018 Latency SHALL be fixed: for an accepting edge at cycle 0, done is high during cycle WIDTH+1.
REQ-019 Throughput SHALL be one operation per WIDTH+2 cycles when start is held high.
REQ-020 The start signal SHALL be ignored in SHIFT and DONE; no request queuing.
REQ-021 Changes on a_in/b_in after the accepting edge SHALL NOT affect the result.
REQ-022 The busy output SHALL be registered: 0 in IDLE, 1 in SHIFT and in DONE.
REQ-023 sum_out and cout SHALL change only on DONE entry or on reset.
REQ-024 Overflow SHALL wrap modulo 2^WIDTH, with the carry reported on cout.

Reset
REQ-025 While rst_n=0 at a clk edge, the FSM SHALL go to IDLE; busy=0, done=0, sum_out=0, cout=0, and operand, carry and counter registers SHALL be 0.
REQ-026 A reset asserted mid-operation SHALL abort the operation; no done pulse for the aborted operation and no update of sum_out.
REQ-027 The first accepting edge SHALL be the first edge with rst_n=1 and start=1.

Structure
REQ-028 Package serial_add_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-029 The package SHALL hold the counter-width function, $clog2(WIDTH+1).
REQ-030 The half-adder cell SHALL be a separate sub-module named half_adder (inputs a, b; outputs s = a XOR b, c = a AND b), instantiated twice.
REQ-031 The design SHALL have no combinational path from inputs to outputs; all outputs are registered.

Verification (WIDTH=8)
REQ-032 Test: start pulse with A=0x5A, B=0x3C -> done at cycle 9, sum_out=0x96, cout=0.
REQ-033 Test: A=0xFF, B=0x01 -> sum_out=0x00, cout=1. Test: A=0xFF, B=0xFF -> sum_out=0xFE, cout=1.
REQ-034 Test: start held high, with A/B changed each operation -> done pulses every 10 cycles, each result matches the operands captured at its accepting edge.
REQ-035 Test: start pulse plus a_in/b_in changed during busy -> pulse ignored, result uses the original operands.
REQ-036 Test: rst_n=0 at cycle 4 of an operation -> next cycle busy=0, sum_out=0, cout=0, no done pulse; a new start afterwards completes normally.
